// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I pipeline sequencer:
// FSM state encoding, forwarding selects and the decode bundle width.
package rv_pipe_pkg;

  localparam int unsigned CTRL_W = 12;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // The younger producer (MEM) must win over WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
      sel = FWD_MEM;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// EX-stage operand forwarding selects.
// Purely combinational, active in every sequencer state.
module pipe_fwd_unit
  import rv_pipe_pkg::*;
(
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic [4:0] i_mem_rd,
  input  logic [4:0] i_wb_rd,
  input  logic       i_mem_reg_write,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b
);

  assign o_fwd_a = fwd_sel(i_ex_rs1,
                           i_mem_reg_write, i_mem_rd,
                           i_wb_reg_write, i_wb_rd);

  assign o_fwd_b = fwd_sel(i_ex_rs2,
                           i_mem_reg_write, i_mem_rd,
                           i_wb_reg_write, i_wb_rd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/flush/bubble strobes, memory-wait freeze,
// EBREAK drain-and-halt, forwarding selects and perf counters.
module pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned DRAIN_CYC   = 3,
  parameter int unsigned CNT_W       = 32
)
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rs1,
  input  logic [4:0]       i_ex_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_take,
  input  logic [4:0]       i_mem_rd,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_mem_reg_write,
  input  logic             i_wb_reg_write,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  input  logic             i_halt_req,
  input  logic             i_resume,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_pipe_freeze,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_halted,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DRN_W  = $clog2(DRAIN_CYC + 1);

  state_e            r_state;
  state_e            w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [DRN_W-1:0]  r_drain_cnt;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_mem_wait;
  logic w_lu_rs1;
  logic w_lu_rs2;
  logic w_load_use;
  logic w_stall_inc;
  logic w_flush_inc;
  logic w_drain_load;
  logic w_drain_dec;

  assign w_mem_wait = i_dmem_req && !i_dmem_ready;
  assign w_lu_rs1   = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_lu_rs2   = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                      (w_lu_rs1 || w_lu_rs2);

  pipe_fwd_unit u_fwd (
    .i_ex_rs1        (i_ex_rs1),
    .i_ex_rs2        (i_ex_rs2),
    .i_mem_rd        (i_mem_rd),
    .i_wb_rd         (i_wb_rd),
    .i_mem_reg_write (i_mem_reg_write),
    .i_wb_reg_write  (i_wb_reg_write),
    .o_fwd_a         (o_fwd_a),
    .o_fwd_b         (o_fwd_b)
  );

  always_comb begin
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_freeze  = 1'b0;
    w_next         = r_state;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    w_drain_load   = 1'b0;
    w_drain_dec    = 1'b0;
    if (!i_reset) begin
      unique case (r_state)
        RUN, MEM_WAIT: begin
          if ((r_state == MEM_WAIT) && !i_dmem_ready) begin
            o_pipe_freeze = 1'b1;
            w_stall_inc   = 1'b1;
          end else begin
            // The release cycle of a wait is an ordinary RUN cycle.
            w_next        = RUN;
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
            if (w_mem_wait) begin
              o_pc_write    = 1'b0;
              o_if_id_write = 1'b0;
              o_pipe_freeze = 1'b1;
              w_stall_inc   = 1'b1;
              w_next        = MEM_WAIT;
            end else if (i_ex_take) begin
              o_if_id_flush  = 1'b1;
              o_id_ex_bubble = 1'b1;
              w_flush_inc    = 1'b1;
            end else if (i_halt_req) begin
              w_next       = DRAIN;
              w_drain_load = 1'b1;
            end else if (w_load_use) begin
              o_pc_write     = 1'b0;
              o_if_id_write  = 1'b0;
              o_id_ex_bubble = 1'b1;
              w_stall_inc    = 1'b1;
            end
          end
        end
        DRAIN: begin
          o_if_id_flush = 1'b1;
          if (w_mem_wait) begin
            o_pipe_freeze = 1'b1;
            w_stall_inc   = 1'b1;
          end else begin
            o_if_id_write = 1'b1;
            w_drain_dec   = 1'b1;
            if (r_drain_cnt <= DRN_W'(1))
              w_next = HALTED;
          end
        end
        HALTED: begin
          o_if_id_flush = 1'b1;
          o_pipe_freeze = 1'b1;
          if (i_resume)
            w_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_stall_inc)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_drain_load)
        r_drain_cnt <= DRN_W'(DRAIN_CYC);
      else if (w_drain_dec)
        r_drain_cnt <= r_drain_cnt - DRN_W'(1);
      // Counts every cycle spent in MEM_WAIT, saturating at the limit.
      if (r_state == MEM_WAIT) begin
        if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT))
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1))
          r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign o_halted      = (r_state == HALTED);
  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table,
// directed multi-cycle sequences and random traffic vs a reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TMO  = 3;
  localparam int unsigned DRN  = 3;
  localparam int unsigned CW   = 32;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       use1;
    logic       use2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_mr;
    logic       take;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       mem_we;
    logic       wb_we;
    logic       req;
    logic       rdy;
    logic       halt;
    logic       resume;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic       pc;
    logic       ifid;
    logic       flush;
    logic       bubble;
    logic       freeze;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
  logic [4:0]    mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_take;
  logic          mem_reg_write, wb_reg_write;
  logic          dmem_req, dmem_ready, halt_req, resume;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic          pipe_freeze, halted, mem_timeout;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit            m_halted;
  int            m_drain;
  bit            m_waiting;
  int            m_wait_n;
  bit            m_tmo;
  logic [CW-1:0] m_stall;
  logic [CW-1:0] m_flush;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (TMO),
    .DRAIN_CYC   (DRN),
    .CNT_W       (CW)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_id_rs1        (id_rs1),
    .i_id_rs2        (id_rs2),
    .i_id_use_rs1    (id_use_rs1),
    .i_id_use_rs2    (id_use_rs2),
    .i_ex_rs1        (ex_rs1),
    .i_ex_rs2        (ex_rs2),
    .i_ex_rd         (ex_rd),
    .i_ex_mem_read   (ex_mem_read),
    .i_ex_take       (ex_take),
    .i_mem_rd        (mem_rd),
    .i_wb_rd         (wb_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_reg_write  (wb_reg_write),
    .i_dmem_req      (dmem_req),
    .i_dmem_ready    (dmem_ready),
    .i_halt_req      (halt_req),
    .i_resume        (resume),
    .o_pc_write      (pc_write),
    .o_if_id_write   (if_id_write),
    .o_if_id_flush   (if_id_flush),
    .o_id_ex_bubble  (id_ex_bubble),
    .o_pipe_freeze   (pipe_freeze),
    .o_fwd_a         (fwd_a),
    .o_fwd_b         (fwd_b),
    .o_halted        (halted),
    .o_mem_timeout   (mem_timeout),
    .o_stall_cnt     (stall_cnt),
    .o_flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs,
                                         input in_t x);
    if (rs == 0) return 2'b00;
    if (x.mem_we && x.mem_rd == rs) return 2'b10;
    if (x.wb_we && x.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(input in_t x);
    reset         = x.rst;
    id_rs1        = x.id_rs1;
    id_rs2        = x.id_rs2;
    id_use_rs1    = x.use1;
    id_use_rs2    = x.use2;
    ex_rs1        = x.ex_rs1;
    ex_rs2        = x.ex_rs2;
    ex_rd         = x.ex_rd;
    ex_mem_read   = x.ex_mr;
    ex_take       = x.take;
    mem_rd        = x.mem_rd;
    wb_rd         = x.wb_rd;
    mem_reg_write = x.mem_we;
    wb_reg_write  = x.wb_we;
    dmem_req      = x.req;
    dmem_ready    = x.rdy;
    halt_req      = x.halt;
    resume        = x.resume;
  endtask

  // Predict this cycle's outputs, compare, then advance the model
  // to the state it holds after the coming clock edge.
  task automatic model_step(input in_t x);
    bit mw, lu;
    logic pc, ifid, fl, bub, frz;
    mw = x.req && !x.rdy;
    lu = x.ex_mr && (x.ex_rd != 0) &&
         ((x.use1 && x.id_rs1 == x.ex_rd) ||
          (x.use2 && x.id_rs2 == x.ex_rd));
    {pc, ifid, fl, bub, frz} = '0;
    chk("halted", halted, m_halted);
    chk("mem_timeout", mem_timeout, m_tmo);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("fwd_a", fwd_a, ref_fwd(x.ex_rs1, x));
    chk("fwd_b", fwd_b, ref_fwd(x.ex_rs2, x));
    if (x.rst) begin
      m_halted = 0; m_drain = 0; m_waiting = 0;
      m_wait_n = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
    end else if (m_halted) begin
      fl = 1; frz = 1;
      if (x.resume) m_halted = 0;
    end else if (m_drain > 0) begin
      fl = 1;
      if (mw) begin
        frz = 1; m_stall++;
      end else begin
        ifid = 1; m_drain--;
        if (m_drain == 0) m_halted = 1;
      end
    end else begin
      if (m_waiting) begin
        m_wait_n++;
        if (m_wait_n >= TMO) m_tmo = 1;
      end
      if (m_waiting && !x.rdy) begin
        frz = 1; m_stall++;
      end else begin
        m_waiting = 0;
        pc = 1; ifid = 1;
        if (mw) begin
          pc = 0; ifid = 0; frz = 1; m_stall++;
          m_waiting = 1; m_wait_n = 0;
        end else if (x.take) begin
          fl = 1; bub = 1; m_flush++;
        end else if (x.halt) begin
          m_drain = DRN;
        end else if (lu) begin
          pc = 0; ifid = 0; bub = 1; m_stall++;
        end
      end
    end
    chk("pc_write", pc_write, pc);
    chk("if_id_write", if_id_write, ifid);
    chk("if_id_flush", if_id_flush, fl);
    chk("id_ex_bubble", id_ex_bubble, bub);
    chk("pipe_freeze", pipe_freeze, frz);
  endtask

  task automatic cycle(input in_t x);
    @(negedge clk);
    drive(x);
    #1;
    model_step(x);
  endtask

  task automatic idle(input int n);
    in_t z;
    z = '0;
    for (int k = 0; k < n; k++) cycle(z);
  endtask

  task automatic do_reset();
    in_t z;
    z = '0;
    z.rst = 1'b1;
    cycle(z);
    cycle(z);
  endtask

  vec_t tbl[11];
  in_t  x;
  int   cnt;

  initial begin
    drive(in_t'(0));
    reset = 1'b1;
    m_halted = 0; m_drain = 0; m_waiting = 0;
    m_wait_n = 0; m_tmo = 0; m_stall = 0; m_flush = 0;

    tbl[0]  = '{i: '{default: '0},
                pc: 1, ifid: 1, default: '0};
    tbl[1]  = '{i: '{ex_mr: 1, ex_rd: 5, id_rs1: 5, use1: 1,
                     default: '0},
                bubble: 1, default: '0};
    tbl[2]  = '{i: '{ex_mr: 1, ex_rd: 0, id_rs1: 0, use1: 1,
                     default: '0},
                pc: 1, ifid: 1, default: '0};
    tbl[3]  = '{i: '{ex_mr: 1, ex_rd: 5, id_rs1: 5, use1: 0,
                     default: '0},
                pc: 1, ifid: 1, default: '0};
    tbl[4]  = '{i: '{ex_mr: 1, ex_rd: 9, id_rs2: 9, use2: 1,
                     default: '0},
                bubble: 1, default: '0};
    tbl[5]  = '{i: '{ex_mr: 0, ex_rd: 9, id_rs2: 9, use2: 1,
                     default: '0},
                pc: 1, ifid: 1, default: '0};
    tbl[6]  = '{i: '{take: 1, ex_mr: 1, ex_rd: 5, id_rs1: 5, use1: 1,
                     default: '0},
                pc: 1, ifid: 1, flush: 1, bubble: 1, default: '0};
    tbl[7]  = '{i: '{mem_rd: 7, wb_rd: 7, ex_rs1: 7, ex_rs2: 0,
                     mem_we: 1, wb_we: 1, default: '0},
                pc: 1, ifid: 1, fa: 2'b10, default: '0};
    tbl[8]  = '{i: '{mem_rd: 7, wb_rd: 7, ex_rs1: 7, mem_we: 0,
                     wb_we: 1, default: '0},
                pc: 1, ifid: 1, fa: 2'b01, default: '0};
    tbl[9]  = '{i: '{mem_rd: 7, wb_rd: 7, ex_rs2: 7, mem_we: 1,
                     wb_we: 1, default: '0},
                pc: 1, ifid: 1, fb: 2'b10, default: '0};
    tbl[10] = '{i: '{mem_rd: 0, wb_rd: 0, ex_rs1: 0, ex_rs2: 0,
                     mem_we: 1, wb_we: 1, default: '0},
                pc: 1, ifid: 1, default: '0};

    // reset state
    do_reset();
    idle(1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_halted", halted, 0);

    for (int k = 0; k < 11; k++) begin
      cycle(tbl[k].i);
      chk($sformatf("v%0d_pc", k), pc_write, tbl[k].pc);
      chk($sformatf("v%0d_ifid", k), if_id_write, tbl[k].ifid);
      chk($sformatf("v%0d_flush", k), if_id_flush, tbl[k].flush);
      chk($sformatf("v%0d_bub", k), id_ex_bubble, tbl[k].bubble);
      chk($sformatf("v%0d_frz", k), pipe_freeze, tbl[k].freeze);
      chk($sformatf("v%0d_fa", k), fwd_a, tbl[k].fa);
      chk($sformatf("v%0d_fb", k), fwd_b, tbl[k].fb);
    end

    // load-use counts one stall
    do_reset();
    cycle(tbl[1].i);
    idle(1);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_one_cycle", pc_write, 1);

    // redirect beats load-use
    do_reset();
    cycle(tbl[6].i);
    idle(1);
    chk("take_flush_cnt", flush_cnt, 1);
    chk("take_stall_cnt", stall_cnt, 0);

    // short wait stays below the timeout
    do_reset();
    x = '0; x.req = 1;
    cycle(x); cycle(x);
    x.rdy = 1;
    cycle(x);
    idle(1);
    chk("short_wait_tmo", mem_timeout, 0);
    chk("short_wait_stall", stall_cnt, 2);

    // 4-cycle wait: freeze count, stall_cnt, sticky timeout
    do_reset();
    x = '0; x.req = 1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(x);
      if (pipe_freeze) cnt++;
    end
    x.rdy = 1;
    cycle(x);
    chk("wait_release", pipe_freeze, 0);
    chk("wait_freeze_cycles", cnt, 4);
    idle(3);
    chk("wait_stall_cnt", stall_cnt, 4);
    chk("wait_tmo_sticky", mem_timeout, 1);

    // halt drains for DRAIN_CYC cycles
    do_reset();
    x = '0; x.halt = 1;
    cycle(x);
    cnt = 0;
    for (int k = 0; k < 20 && !halted; k++) begin
      idle(1);
      if (!halted) cnt++;
    end
    chk("drain_cycles", cnt, 3);
    chk("halted_set", halted, 1);
    x = '0; x.resume = 1;
    cycle(x);
    idle(1);
    chk("resume_halted", halted, 0);
    chk("resume_pc", pc_write, 1);

    // memory wait inside DRAIN pauses the drain
    do_reset();
    x = '0; x.halt = 1;
    cycle(x);
    idle(1);
    x = '0; x.req = 1;
    cycle(x); cycle(x);
    cnt = 3;
    for (int k = 0; k < 20 && !halted; k++) begin
      idle(1);
      if (!halted) cnt++;
    end
    chk("drain_wait_cycles", cnt, 5);

    // reset in the middle of a wait
    do_reset();
    x = '0; x.req = 1;
    for (int k = 0; k < 5; k++) cycle(x);
    do_reset();
    idle(1);
    chk("midwait_tmo", mem_timeout, 0);
    chk("midwait_stall", stall_cnt, 0);
    chk("midwait_pc", pc_write, 1);

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      x = '0;
      x.rst    = ($urandom_range(0, 99) == 0);
      x.id_rs1 = 5'($urandom_range(0, 3));
      x.id_rs2 = 5'($urandom_range(0, 3));
      x.use1   = 1'($urandom);
      x.use2   = 1'($urandom);
      x.ex_rs1 = 5'($urandom_range(0, 3));
      x.ex_rs2 = 5'($urandom_range(0, 3));
      x.ex_rd  = 5'($urandom_range(0, 3));
      x.ex_mr  = 1'($urandom);
      x.take   = ($urandom_range(0, 5) == 0);
      x.mem_rd = 5'($urandom_range(0, 3));
      x.wb_rd  = 5'($urandom_range(0, 3));
      x.mem_we = 1'($urandom);
      x.wb_we  = 1'($urandom);
      x.req    = ($urandom_range(0, 3) == 0);
      x.rdy    = 1'($urandom);
      x.halt   = ($urandom_range(0, 15) == 0);
      x.resume = ($urandom_range(0, 3) == 0);
      cycle(x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencer for the 5-stage RV32I core. Sits beside the decode stage and generates stall, flush and bubble strobes for the PC, IF/ID and ID/EX registers, plus EX-stage forwarding selects. It freezes the pipeline on data-memory wait, drains and halts on EBREAK, and keeps stall/flush performance counters.

Parameters:
CTRL_W, 12, width of the decode control bundle zeroed by a bubble
MEM_TIMEOUT, 255, wait cycles before mem_timeout is raised
DRAIN_CYC, 3, cycles to retire in-flight instructions after halt_req
CNT_W, 32, performance counter width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
id_rs1, id_rs2  in  5 each  source registers of instruction in ID
id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  5 each  sources of instruction in EX
ex_rd  in  5  EX destination
ex_mem_read  in  1  EX instruction is a load
ex_take  in  1  branch taken or JAL/JALR resolved in EX
mem_rd, wb_rd  in  5 each  MEM and WB destinations
mem_reg_write, wb_reg_write  in  1 each  destination write enables
dmem_req, dmem_ready  in  1 each  data memory request and completion
halt_req  in  1  EBREAK decoded in ID
resume  in  1  leave HALTED
pc_write, if_id_write  out  1 each  register enables
if_id_flush, id_ex_bubble  out  1 each  clear IF/ID; load CTRL_W'b0 controls into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
fwd_a, fwd_b  out  2 each  00 register file, 10 from MEM, 01 from WB
halted, mem_timeout  out  1 each  status; mem_timeout is sticky
stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset values: state RUN, counters 0, mem_timeout 0. While reset is high, pc_write=0 and if_id_write=0.
- FSM states:
  - RUN: pc_write=1, if_id_write=1, no flush, no freeze.
  - MEM_WAIT: full freeze, pc_write=0.
  - DRAIN: pc_write=0, if_id_flush=1, the rest of the pipeline runs.
  - HALTED: pc_write=0, if_id_flush=1, pipe_freeze=1, halted=1.
- Priority within a cycle in RUN: memory wait, then ex_take, then halt_req, then load-use.
- Memory wait: dmem_req && !dmem_ready freezes the same cycle (combinational) and the next state is MEM_WAIT. In MEM_WAIT the freeze holds while !dmem_ready. The cycle dmem_ready=1 gives RUN outputs and the next state is RUN.
- Wait counter: increments each MEM_WAIT cycle. At MEM_TIMEOUT it sets mem_timeout and saturates; the FSM keeps waiting.
- Redirect: ex_take asserts if_id_flush=1 and id_ex_bubble=1 for one cycle, with pc_write=1 so the target loads. flush_cnt+1.
- Load-use: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)) gives pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle. stall_cnt+1.
- Simultaneous events:
  - ex_take with load-use: ex_take wins and no stall is counted.
  - ex_take with halt_req: flush wins and the halt is discarded.
- Halt entry: halt_req in RUN (no higher event) goes to DRAIN and loads the drain counter with DRAIN_CYC.
- DRAIN: a memory wait inside DRAIN freezes and pauses the drain counter. The counter reaching 0 moves to HALTED.
- Leaving HALTED: resume returns to RUN next cycle.
- Forwarding (combinational, all states):
  - fwd_a=10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1.
  - Otherwise fwd_a=01 if the same test passes with wb_reg_write and wb_rd.
  - Otherwise fwd_a=00. fwd_b is the same using ex_rs2. MEM beats WB.
- Counters wrap modulo 2^CNT_W. stall_cnt also increments once per MEM_WAIT freeze cycle.
- Reset mid-wait or mid-drain returns to RUN, clears the counters and clears mem_timeout.

Decomposition:
- Shared package rv_pipe_pkg: state encoding (RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3), FWD_RF/FWD_MEM/FWD_WB constants, CTRL_W.
- One sub-module, pipe_fwd_unit: the combinational forwarding selects. The FSM and counters stay in the top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt 0->1.
- Same, but ex_rd=0 or id_use_rs1=0 -> no stall.
- ex_take=1 together with the load-use condition -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- dmem_req=1 with dmem_ready low for 4 cycles -> pipe_freeze high 4 cycles then released; stall_cnt=4. With MEM_TIMEOUT=3 -> mem_timeout=1 and stays set after release.
- halt_req pulse -> DRAIN for 3 cycles, then halted=1. A 2-cycle memory wait during DRAIN delays halted by 2 cycles. resume -> RUN next cycle.
- Forwarding: mem_rd=wb_rd=ex_rs1=7, both writes set -> fwd_a=10. mem_reg_write=0 -> fwd_a=01. ex_rs2=0 -> fwd_b=00.
